vmi_seq_ctrl: RTL and testbench
===============================

VMI_SEQ_CTRL -- requirements
Module: vmi_seq_ctrl

Interface
REQ-001 SHALL have parameter OPCODE_W, default 8, meaning the opcode width in bits.
REQ-002 SHALL have port clk  in  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port reset_n  in  1  reset, asynchronous, active-low; this is the single clock and reset for the block.
REQ-004 SHALL have port opcode  in  OPCODE_W  instruction register opcode field.
REQ-005 SHALL have port zero  in  1  ALU zero flag.
REQ-006 SHALL have ports imem_ready and dmem_ready  in  1 each  memory completion strobes.
REQ-007 SHALL have ports imem_req and dmem_req  out  1 each  memory request, held until ready.
REQ-008 SHALL have ports irWrite, pcWrite, regWrite, memWrite  out  1 each  datapath write enables.
REQ-009 SHALL have port pcSrc  out  2  PC select: 00 pc+1, 01 immediate target, 10 register.
REQ-010 SHALL have ports aluSrcA, aluSrcB  out  1 each, aluControl  out  2, and resultSrc  out  2 (00 ALU, 01 memory, 10 pc+1), with the existing opcode-to-control encoding.
REQ-011 SHALL have port instr_done  out  1  one-cycle pulse on the final cycle of each instruction.

Function
REQ-012 SHALL implement the Moore FSM states FETCH, DECODE, EXEC, MEM, WB.
REQ-013 FETCH: imem_req=1. On imem_ready: irWrite=1, pcWrite=1, pcSrc=00 in the same cycle, then go to DECODE. Otherwise stay in FETCH.
REQ-014 DECODE: SHALL latch opcode into op_q, which is the only point where opcode is sampled. NOP (0x00) and undefined opcodes go to FETCH with instr_done=1. All other opcodes go to EXEC.
REQ-015 EXEC with ALU/MOV ops (0x01-0x0a): aluSrcA/aluSrcB/aluControl per the existing table, then go to WB.
REQ-016 EXEC with LDR/STR (0x0b/0x0c): aluSrcB=1, aluControl=00, then go to MEM.
REQ-017 EXEC with B (0x0d): pcWrite=1, pcSrc=01, instr_done=1, then go to FETCH.
REQ-018 EXEC with BEQ/BNE (0x0e/0x0f): aluControl=01. pcWrite=zero for BEQ and pcWrite=!zero for BNE, pcSrc=01, instr_done=1, then go to FETCH.
REQ-019 EXEC with BL (0x10): pcWrite=1, pcSrc=01, then go to WB with resultSrc=10. The link value is pc+1, captured before the PC update.
REQ-020 EXEC with BRN (0x11): pcWrite=1, pcSrc=10, instr_done=1, then go to FETCH.
REQ-021 MEM: dmem_req=1, and for STR memWrite=1 while the request is held. On dmem_ready, STR goes to FETCH with instr_done=1 and LDR goes to WB. Otherwise stay in MEM.
REQ-022 WB: regWrite=1 for exactly one cycle, resultSrc per op_q (ALU ops 00, LDR 01, BL 10), instr_done=1, then go to FETCH.
REQ-023 All enables SHALL be 0 in any state or opcode not listed above.
REQ-024 Required latencies with zero wait states: NOP 2, branches 3, ALU/MOV 4, STR 4, LDR 5 cycles. Each wait cycle adds exactly 1.
REQ-025 A ready strobe arriving in a state that does not request that memory SHALL be ignored.
REQ-026 At most one of imem_req and dmem_req SHALL be high in any cycle.
REQ-027 A write enable SHALL never be asserted for more than one cycle per instruction, except memWrite, which is held for the duration of dmem_req.

Reset
REQ-028 On reset_n low, the FSM SHALL enter FETCH asynchronously, op_q SHALL be 0, and every output SHALL be 0 except imem_req.
REQ-029 imem_req SHALL rise on the first clock edge after reset_n deasserts.
REQ-030 Reset during MEM or FETCH SHALL drop the request immediately with no write enable pulse.

Structure
REQ-031 A shared package vmi_pkg SHALL hold the opcode localparams, the state enum, and the pcSrc/resultSrc encodings.
REQ-032 The opcode-to-ALU-control mapping SHALL live in one combinational sub-module, vmi_op_decode, which is instantiated on op_q.

Verification
REQ-033 ADD_R (0x01), zero wait states -> FETCH/DECODE/EXEC/WB, regWrite in cycle 4 only, instr_done in cycle 4.
REQ-034 LDR (0x0b) with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, then WB with resultSrc=01, total 8 cycles.
REQ-035 BEQ (0x0e) with zero=1 -> pcWrite=1 with pcSrc=01 in EXEC. With zero=0 -> pcWrite=0 and a return to FETCH.
REQ-036 BL (0x10) -> pcWrite in EXEC, then regWrite with resultSrc=10 in WB, 4 cycles total.
REQ-037 STR (0x0c) with reset_n pulsed low during MEM -> memWrite and dmem_req drop asynchronously, FSM in FETCH, no regWrite.
REQ-038 Opcode 0xFF -> treated as NOP: 2 cycles, no write enable other than the fetch irWrite/pcWrite.

Source files
------------

// File: rtl/vmi_pkg.sv
// vmi_pkg: shared definitions for the VMI sequencer.
//   - opcode values (8-bit reference encoding)
//   - sequencer state enum
//   - opcode class enum, produced by vmi_op_decode
//   - pcSrc / resultSrc mux encodings
package vmi_pkg;

   localparam logic [7:0] OP_NOP   = 8'h00;
   localparam logic [7:0] OP_ADD_R = 8'h01;
   localparam logic [7:0] OP_ADD_I = 8'h02;
   localparam logic [7:0] OP_SUB_R = 8'h03;
   localparam logic [7:0] OP_SUB_I = 8'h04;
   localparam logic [7:0] OP_AND_R = 8'h05;
   localparam logic [7:0] OP_AND_I = 8'h06;
   localparam logic [7:0] OP_ORR_R = 8'h07;
   localparam logic [7:0] OP_ORR_I = 8'h08;
   localparam logic [7:0] OP_MOV_R = 8'h09;
   localparam logic [7:0] OP_MOV_I = 8'h0a;
   localparam logic [7:0] OP_LDR   = 8'h0b;
   localparam logic [7:0] OP_STR   = 8'h0c;
   localparam logic [7:0] OP_B     = 8'h0d;
   localparam logic [7:0] OP_BEQ   = 8'h0e;
   localparam logic [7:0] OP_BNE   = 8'h0f;
   localparam logic [7:0] OP_BL    = 8'h10;
   localparam logic [7:0] OP_BRN   = 8'h11;

   typedef enum logic [2:0] {
      ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB
   } state_t;

   typedef enum logic [3:0] {
      CL_NONE, CL_ALU, CL_LDR, CL_STR, CL_B, CL_BEQ, CL_BNE, CL_BL, CL_BRN
   } opClass_t;

   localparam logic [1:0] PC_PLUS1 = 2'b00;
   localparam logic [1:0] PC_IMM   = 2'b01;
   localparam logic [1:0] PC_REG   = 2'b10;

   localparam logic [1:0] RES_ALU  = 2'b00;
   localparam logic [1:0] RES_MEM  = 2'b01;
   localparam logic [1:0] RES_PC1  = 2'b10;

endpackage

// File: rtl/vmi_op_decode.sv
// vmi_op_decode: purely combinational opcode-to-control mapping.
// Ports:
//   op          in  latched opcode
//   opClass     out instruction class used by the sequencer
//   aluSrcA     out 1 = ALU A operand forced to zero (MOV)
//   aluSrcB     out 1 = ALU B operand from immediate
//   aluControl  out 00 add, 01 sub, 10 and, 11 or
module vmi_op_decode
   import vmi_pkg::*;
#(
   parameter int OPCODE_W = 8
) (
   input  logic [OPCODE_W-1:0] op,
   output opClass_t            opClass,
   output logic                aluSrcA,
   output logic                aluSrcB,
   output logic [1:0]          aluControl
);

   always_comb begin
      opClass    = CL_NONE;
      aluSrcA    = 1'b0;
      aluSrcB    = 1'b0;
      aluControl = 2'b00;
      case (op)
         OPCODE_W'(OP_ADD_R): opClass = CL_ALU;
         OPCODE_W'(OP_ADD_I): begin opClass = CL_ALU; aluSrcB = 1'b1; end
         OPCODE_W'(OP_SUB_R): begin opClass = CL_ALU; aluControl = 2'b01; end
         OPCODE_W'(OP_SUB_I): begin opClass = CL_ALU; aluSrcB = 1'b1; aluControl = 2'b01; end
         OPCODE_W'(OP_AND_R): begin opClass = CL_ALU; aluControl = 2'b10; end
         OPCODE_W'(OP_AND_I): begin opClass = CL_ALU; aluSrcB = 1'b1; aluControl = 2'b10; end
         OPCODE_W'(OP_ORR_R): begin opClass = CL_ALU; aluControl = 2'b11; end
         OPCODE_W'(OP_ORR_I): begin opClass = CL_ALU; aluSrcB = 1'b1; aluControl = 2'b11; end
         OPCODE_W'(OP_MOV_R): begin opClass = CL_ALU; aluSrcA = 1'b1; end
         OPCODE_W'(OP_MOV_I): begin opClass = CL_ALU; aluSrcA = 1'b1; aluSrcB = 1'b1; end
         // address = base + immediate offset
         OPCODE_W'(OP_LDR):   begin opClass = CL_LDR; aluSrcB = 1'b1; end
         OPCODE_W'(OP_STR):   begin opClass = CL_STR; aluSrcB = 1'b1; end
         OPCODE_W'(OP_B):     opClass = CL_B;
         // compare by subtraction; zero flag decides the branch
         OPCODE_W'(OP_BEQ):   begin opClass = CL_BEQ; aluControl = 2'b01; end
         OPCODE_W'(OP_BNE):   begin opClass = CL_BNE; aluControl = 2'b01; end
         OPCODE_W'(OP_BL):    opClass = CL_BL;
         OPCODE_W'(OP_BRN):   opClass = CL_BRN;
         default:             opClass = CL_NONE;
      endcase
   end

endmodule

// File: rtl/vmi_seq_ctrl.sv
// vmi_seq_ctrl: multi-cycle instruction sequencer (FETCH/DECODE/EXEC/MEM/WB).
// Ports:
//   clk, reset_n              clock, async active-low reset
//   opcode                    IR opcode field, sampled only in DECODE
//   zero                      ALU zero flag (BEQ/BNE)
//   imem_ready, dmem_ready    memory completion strobes
//   imem_req, dmem_req        memory requests, held until ready
//   irWrite, pcWrite,
//   regWrite, memWrite        datapath write enables
//   pcSrc                     00 pc+1, 01 immediate target, 10 register
//   aluSrcA, aluSrcB,
//   aluControl                ALU operand/operation select (EXEC only)
//   resultSrc                 00 ALU, 01 memory, 10 pc+1 (WB only)
//   instr_done                pulse on the last cycle of each instruction
module vmi_seq_ctrl
   import vmi_pkg::*;
#(
   parameter int OPCODE_W = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero,
   input  logic                imem_ready,
   input  logic                dmem_ready,
   output logic                imem_req,
   output logic                dmem_req,
   output logic                irWrite,
   output logic                pcWrite,
   output logic                regWrite,
   output logic                memWrite,
   output logic [1:0]          pcSrc,
   output logic                aluSrcA,
   output logic                aluSrcB,
   output logic [1:0]          aluControl,
   output logic [1:0]          resultSrc,
   output logic                instr_done
);

   state_t              state, stateNext;
   logic [OPCODE_W-1:0] op_q;
   // Low in reset and until the first edge after release, so FETCH outputs
   // (including imem_req) stay quiet during and right after reset.
   logic                armed;

   opClass_t            opClass;
   logic                decSrcA, decSrcB;
   logic [1:0]          decCtl;
   logic                opValid;

   vmi_op_decode #(.OPCODE_W(OPCODE_W)) uDecode (
      .op         (op_q),
      .opClass    (opClass),
      .aluSrcA    (decSrcA),
      .aluSrcB    (decSrcB),
      .aluControl (decCtl)
   );

   // Decoded opcodes are contiguous 0x01..0x11; anything else runs as NOP.
   assign opValid = (opcode != OPCODE_W'(OP_NOP)) && (opcode <= OPCODE_W'(OP_BRN));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_FETCH;
         op_q  <= '0;
         armed <= 1'b0;
      end else begin
         armed <= 1'b1;
         state <= stateNext;
         if (state == ST_DECODE) op_q <= opcode;
      end
   end

   always_comb begin
      stateNext  = state;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      irWrite    = 1'b0;
      pcWrite    = 1'b0;
      regWrite   = 1'b0;
      memWrite   = 1'b0;
      pcSrc      = PC_PLUS1;
      aluSrcA    = 1'b0;
      aluSrcB    = 1'b0;
      aluControl = 2'b00;
      resultSrc  = RES_ALU;
      instr_done = 1'b0;
      case (state)
         ST_FETCH: begin
            imem_req = armed;
            if (armed && imem_ready) begin
               irWrite   = 1'b1;
               pcWrite   = 1'b1;
               stateNext = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (opValid) begin
               stateNext = ST_EXEC;
            end else begin
               instr_done = 1'b1;
               stateNext  = ST_FETCH;
            end
         end
         ST_EXEC: begin
            aluSrcA    = decSrcA;
            aluSrcB    = decSrcB;
            aluControl = decCtl;
            stateNext  = ST_FETCH;
            case (opClass)
               CL_ALU:           stateNext = ST_WB;
               CL_LDR, CL_STR:   stateNext = ST_MEM;
               CL_B:   begin pcWrite = 1'b1;  pcSrc = PC_IMM; instr_done = 1'b1; end
               CL_BEQ: begin pcWrite = zero;  pcSrc = PC_IMM; instr_done = 1'b1; end
               CL_BNE: begin pcWrite = !zero; pcSrc = PC_IMM; instr_done = 1'b1; end
               // The datapath keeps the pre-update pc+1 as the link value for WB.
               CL_BL:  begin pcWrite = 1'b1;  pcSrc = PC_IMM; stateNext = ST_WB; end
               CL_BRN: begin pcWrite = 1'b1;  pcSrc = PC_REG; instr_done = 1'b1; end
               default: instr_done = 1'b1;
            endcase
         end
         ST_MEM: begin
            dmem_req = 1'b1;
            memWrite = (opClass == CL_STR);
            if (dmem_ready) begin
               if (opClass == CL_STR) begin
                  instr_done = 1'b1;
                  stateNext  = ST_FETCH;
               end else begin
                  stateNext  = ST_WB;
               end
            end
         end
         ST_WB: begin
            regWrite   = 1'b1;
            instr_done = 1'b1;
            stateNext  = ST_FETCH;
            case (opClass)
               CL_LDR:  resultSrc = RES_MEM;
               CL_BL:   resultSrc = RES_PC1;
               default: resultSrc = RES_ALU;
            endcase
         end
         default: stateNext = ST_FETCH;
      endcase
   end

endmodule

// File: tb/tb_vmi_seq_ctrl.sv
// tb_vmi_seq_ctrl: directed bench for vmi_seq_ctrl. A trace model builds the
// expected per-cycle outputs of one instruction from its opcode, zero flag
// and wait-state counts; every cycle is compared at the falling edge.
module tb_vmi_seq_ctrl;

   typedef struct packed {
      logic       imemReq, dmemReq, irW, pcW, regW, memW;
      logic [1:0] pcSrc;
      logic       aSrcA, aSrcB;
      logic [1:0] aCtl;
      logic [1:0] resSrc;
      logic       done;
   } outs_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] opcode;
   logic       zero, imem_ready, dmem_ready;
   logic       imem_req, dmem_req, irWrite, pcWrite, regWrite, memWrite;
   logic [1:0] pcSrc, aluControl, resultSrc;
   logic       aluSrcA, aluSrcB, instr_done;

   int checks   = 0;
   int failures = 0;

   outs_t expQ[$];
   logic  iRdyQ[$];
   logic  dRdyQ[$];

   vmi_seq_ctrl #(.OPCODE_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req), .dmem_req(dmem_req), .irWrite(irWrite),
      .pcWrite(pcWrite), .regWrite(regWrite), .memWrite(memWrite),
      .pcSrc(pcSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
      .aluControl(aluControl), .resultSrc(resultSrc), .instr_done(instr_done)
   );

   always #5 clk = ~clk;

   function automatic outs_t curOuts();
      return {imem_req, dmem_req, irWrite, pcWrite, regWrite, memWrite, pcSrc,
              aluSrcA, aluSrcB, aluControl, resultSrc, instr_done};
   endfunction

   task automatic push(input outs_t o, input logic ir, input logic dr);
      expQ.push_back(o); iRdyQ.push_back(ir); dRdyQ.push_back(dr);
   endtask

   // Expected cycle-by-cycle trace of one instruction. iw/dw are wait cycles
   // before imem_ready/dmem_ready; stray drives the other memory's ready high.
   task automatic buildTrace(input int op, input logic z, input int iw, input int dw,
                             input logic stray);
      outs_t o;
      bool_mem: begin end
      expQ.delete(); iRdyQ.delete(); dRdyQ.delete();
      for (int i = 0; i < iw; i++) begin
         o = '0; o.imemReq = 1'b1; push(o, 1'b0, stray);
      end
      o = '0; o.imemReq = 1'b1; o.irW = 1'b1; o.pcW = 1'b1; push(o, 1'b1, stray);
      o = '0;
      if (op < 1 || op > 17) begin
         o.done = 1'b1; push(o, stray, stray); return;
      end
      push(o, stray, stray);
      o = '0;
      if (op <= 8) begin
         o.aSrcB = (op % 2 == 0); o.aCtl = 2'((op - 1) / 2);
      end else if (op <= 10) begin
         o.aSrcA = 1'b1; o.aSrcB = (op == 10);
      end else if (op == 11 || op == 12) begin
         o.aSrcB = 1'b1;
      end else if (op == 13) begin
         o.pcW = 1'b1; o.pcSrc = 2'b01; o.done = 1'b1;
      end else if (op == 14 || op == 15) begin
         o.aCtl = 2'b01; o.pcW = (op == 14) ? z : !z; o.pcSrc = 2'b01; o.done = 1'b1;
      end else if (op == 16) begin
         o.pcW = 1'b1; o.pcSrc = 2'b01;
      end else begin
         o.pcW = 1'b1; o.pcSrc = 2'b10; o.done = 1'b1;
      end
      push(o, stray, stray);
      if (o.done) return;
      if (op == 11 || op == 12) begin
         for (int i = 0; i <= dw; i++) begin
            o = '0; o.dmemReq = 1'b1; o.memW = (op == 12);
            o.done = (op == 12) && (i == dw);
            push(o, stray, i == dw);
         end
         if (op == 12) return;
      end
      o = '0; o.regW = 1'b1; o.done = 1'b1;
      o.resSrc = (op == 11) ? 2'b01 : (op == 16) ? 2'b10 : 2'b00;
      push(o, stray, stray);
   endtask

   task automatic handCheck(input string nm, input outs_t e);
      outs_t a;
      a = curOuts();
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", nm, a, e);
      end
   endtask

   // Entered and left at posedge+2. cut>0 stops after that many cycles.
   task automatic runInstr(input string nm, input int op, input logic z, input int iw,
                           input int dw, input logic stray, input int lat, input int cut);
      int    n, doneCnt, doneAt;
      outs_t a;
      buildTrace(op, z, iw, dw, stray);
      n = (cut > 0) ? cut : expQ.size();
      doneCnt = 0; doneAt = -1;
      for (int c = 0; c < n; c++) begin
         opcode = 8'(op); zero = z; imem_ready = iRdyQ[c]; dmem_ready = dRdyQ[c];
         @(negedge clk);
         a = curOuts();
         checks++;
         if (a !== expQ[c]) begin
            failures++;
            $display("FAIL %s cyc=%0d act=%h exp=%h", nm, c, a, expQ[c]);
         end
         if (instr_done) begin doneCnt++; doneAt = c; end
         @(posedge clk); #2;
      end
      if (cut == 0) begin
         checks++;
         if (doneCnt != 1 || doneAt + 1 != lat) begin
            failures++;
            $display("FAIL %s_latency act=%0d pulses=%0d exp=%0d", nm, doneAt + 1, doneCnt, lat);
         end
      end
   endtask

   task automatic pulseReset(input string nm);
      #1 reset_n = 1'b0;
      #1 handCheck({nm, "_inRst"}, '0);
      @(negedge clk); #1 reset_n = 1'b1;
      imem_ready = 1'b1;
      #1 handCheck({nm, "_rel"}, '0);
      @(posedge clk); #2;
   endtask

   outs_t memHold;

   initial begin
      reset_n = 1'b0; opcode = 8'h00; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
      #12 handCheck("reset", '0);
      #10 reset_n = 1'b1; imem_ready = 1'b1;
      #1 handCheck("relNoReq", '0);
      @(posedge clk); #2;

      runInstr("add_r",  8'h01, 1'b0, 0, 0, 1'b0, 4, 0);
      runInstr("add_i",  8'h02, 1'b0, 2, 0, 1'b1, 6, 0);
      runInstr("sub_r",  8'h03, 1'b0, 0, 0, 1'b0, 4, 0);
      runInstr("orr_i",  8'h08, 1'b0, 1, 0, 1'b0, 5, 0);
      runInstr("mov_i",  8'h0a, 1'b0, 0, 0, 1'b1, 4, 0);
      runInstr("ldr_w3", 8'h0b, 1'b0, 0, 3, 1'b0, 8, 0);
      runInstr("ldr_st", 8'h0b, 1'b0, 0, 1, 1'b1, 6, 0);
      runInstr("str",    8'h0c, 1'b0, 0, 0, 1'b0, 4, 0);
      runInstr("str_w2", 8'h0c, 1'b0, 0, 2, 1'b1, 6, 0);
      runInstr("b",      8'h0d, 1'b0, 0, 0, 1'b0, 3, 0);
      runInstr("beq_z1", 8'h0e, 1'b1, 0, 0, 1'b0, 3, 0);
      runInstr("beq_z0", 8'h0e, 1'b0, 0, 0, 1'b0, 3, 0);
      runInstr("bne_z0", 8'h0f, 1'b0, 0, 0, 1'b1, 3, 0);
      runInstr("bne_z1", 8'h0f, 1'b1, 0, 0, 1'b0, 3, 0);
      runInstr("bl",     8'h10, 1'b0, 0, 0, 1'b0, 4, 0);
      runInstr("brn",    8'h11, 1'b0, 0, 0, 1'b0, 3, 0);
      runInstr("nop",    8'h00, 1'b0, 0, 0, 1'b0, 2, 0);
      runInstr("undefFF",8'hff, 1'b0, 0, 0, 1'b1, 2, 0);
      runInstr("undef12",8'h12, 1'b0, 1, 0, 1'b0, 3, 0);

      // STR interrupted by reset in its second MEM cycle
      runInstr("str_rst", 8'h0c, 1'b0, 0, 5, 1'b0, 0, 4);
      dmem_ready = 1'b0;
      memHold = '0; memHold.dmemReq = 1'b1; memHold.memW = 1'b1;
      #1 handCheck("strMemHeld", memHold);
      pulseReset("strMem");
      runInstr("add_after", 8'h01, 1'b0, 0, 0, 1'b0, 4, 0);

      // reset while FETCH is waiting on imem_ready
      runInstr("fetch_rst", 8'h01, 1'b0, 3, 0, 1'b0, 0, 2);
      pulseReset("fetch");
      runInstr("ldr_after", 8'h0b, 1'b0, 0, 0, 1'b0, 5, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
